spi_bus_arbiter: RTL
====================

# spi_bus_arbiter

Shares the single SPI master engine inside `rv_uart_top` among `N_REQ` requesters, for example core MMIO and a flash/boot loader. Each requester owns one chip-select line. The arbiter grants the bus round-robin for a whole multi-byte transaction and sequences CS setup, byte issue, CS hold and inter-transaction gap. It sits between the requesters and the shift engine that drives `spi_sck`/`mosi`/`miso`.

## Interface
Parameters:
- `N_REQ`, 2: number of requesters and chip selects.
- `DW`, 8: byte width.
- `CS_SETUP`, 2: cycles from CS assert to first issue; must be ≥1.
- `CS_HOLD`, 2: cycles from last byte completion to CS deassert; must be ≥1.
- `IDLE_GAP`, 1: cycles with all CS high before the next grant; must be ≥1.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `Rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  N_REQ  requester wants the bus; level, held for the whole transaction.
- `byte_valid`  in  N_REQ  requester i presents a byte.
- `byte_last`  in  N_REQ  presented byte is the final byte of the transaction.
- `wdata`  in  N_REQ*DW  requester i's byte at `[i*DW +: DW]`.
- `byte_ready`  out  N_REQ  one-cycle pulse: byte accepted (granted requester only).
- `rvalid`  out  N_REQ  one-cycle pulse: `rdata` holds the received byte (granted requester only).
- `rdata`  out  DW  last received byte, broadcast to all requesters.
- `gnt`  out  N_REQ  one-hot grant, or all zero.
- `cs_n`  out  N_REQ  active-low chip selects.
- `eng_start`  out  1  one-cycle pulse that starts one byte transfer.
- `eng_wdata`  out  DW  byte to shift; stable from `eng_start` until `eng_done`.
- `eng_busy`  in  1  engine is shifting.
- `eng_done`  in  1  one-cycle pulse: transfer complete, `eng_rdata` valid.
- `eng_rdata`  in  DW  received byte.

## Operation
- Outputs are registered.
- Reset values: `gnt`=0, `cs_n`=all 1, `byte_ready`=0, `rvalid`=0, `rdata`=0, `eng_start`=0, `eng_wdata`=0. The round-robin pointer resets so that requester 0 has highest priority.
- States are IDLE, SETUP, ISSUE, WAIT, HOLD and GAP.
- IDLE:
  - If any `req` is set, grant the first set bit searching upward from (last granted + 1) mod `N_REQ`.
  - Set `gnt[g]`, clear `cs_n[g]`, record g as last granted, load the counter with `CS_SETUP`, go to SETUP.
- SETUP: count down; at zero go to ISSUE.
- ISSUE:
  - If `byte_valid[g]` and not `eng_busy`: pulse `eng_start` and `byte_ready[g]`, latch `wdata[g]` into `eng_wdata`, latch `byte_last[g]`, go to WAIT.
  - Else if `req[g]` is low: this is an abort. Go to HOLD with no transfer.
- WAIT: on `eng_done`, register `eng_rdata` into `rdata` and pulse `rvalid[g]`. Then go to HOLD if the latched last flag is set, otherwise back to ISSUE.
- HOLD: count `CS_HOLD`. At expiry set `cs_n[g]`=1 and `gnt`=0, then go to GAP.
- GAP: count `IDLE_GAP`, then go to IDLE.
- No preemption: `req` changes from other requesters are ignored outside IDLE. `req[g]` dropping in WAIT or HOLD is ignored.
- `eng_done` outside WAIT is ignored.
- `byte_valid`/`byte_last` from non-granted requesters are ignored.
- At most one `cs_n` bit is low at any time.
- Reset assertion in any state forces all outputs to their reset values immediately, with no clock required.

## Timing
- Let `req` be sampled at edge t0 in IDLE:
  - `gnt`/`cs_n` change at t0+1.
  - ISSUE is entered at t0+1+`CS_SETUP`.
  - If `byte_valid` is already high, `eng_start` and `byte_ready` are high during cycle t0+2+`CS_SETUP`.
- Requester handshake: hold `byte_valid`/`wdata` stable until `byte_ready` is seen, then advance at the next edge. `byte_valid` is not sampled during WAIT.
- `rvalid` is high in the cycle after the `eng_done` cycle. Back-to-back bytes: the next `eng_start` comes no earlier than 2 cycles after `eng_done`.
- `cs_n` rises `CS_HOLD` cycles after the final `rvalid` cycle. The next grant comes no earlier than `IDLE_GAP`+1 cycles after that.
- Arbitration decision latency: 1 cycle.

## Test plan
- Single requester, 2 bytes:
  - Stimulus: requester 0 sends 0xA5 then 0x3C with last set; the engine model returns 0x5A then 0xC3, each 16 cycles after `eng_start`.
  - Required: `cs_n[0]` stays low throughout; exactly 2 `eng_start` pulses with `eng_wdata` 0xA5 then 0x3C; `rvalid[0]` pulses with `rdata` 0x5A then 0xC3; `cs_n[0]` rises `CS_HOLD` cycles after the second `rvalid`.
- Simultaneous requests after reset:
  - Stimulus: `req`=2'b11, each requester sends 1-byte transactions repeatedly.
  - Required: grant order is 0,1,0,1; the `cs_n` low windows never overlap and are separated by ≥`IDLE_GAP` cycles.
- No preemption:
  - Stimulus: requester 1 in a 4-byte transaction; `req[0]` asserts after byte 1.
  - Required: all 4 bytes finish under `gnt`=2'b10; `gnt`=2'b01 only after GAP.
- Abort:
  - Stimulus: `req[0]` drops in ISSUE with `byte_valid[0]`=0.
  - Required: no `eng_start`; `cs_n[0]` returns to 1 after `CS_HOLD` cycles; `rvalid`=0 throughout.
- Engine busy and spurious done:
  - Stimulus: hold `eng_busy`=1 for 10 cycles while in ISSUE with a valid byte; later inject `eng_done` while in IDLE.
  - Required: `eng_start` is delayed until the cycle after `eng_busy` falls; the IDLE `eng_done` produces no `rvalid` and no `rdata` change.
- Reset mid-transaction:
  - Stimulus: assert `Rst_n`=0 during WAIT, between clock edges.
  - Required: `cs_n`=all 1, `gnt`=0, `eng_start`=0 immediately; after release, a request to requester 0 is granted normally.

Source files
------------

// File: rtl/spi_bus_arbiter_if.sv
// Signal bundle between the SPI bus arbiter, its requesters and the
// single shared shift engine. The arbiter uses the master view; the
// requesters/engine side (or a bench) uses the slave view.
interface spi_bus_arbiter_if #(
    parameter int N_REQ = 2,
    parameter int DW    = 8
);
    // requester side
    logic [N_REQ-1:0]    req;
    logic [N_REQ-1:0]    byte_valid;
    logic [N_REQ-1:0]    byte_last;
    logic [N_REQ*DW-1:0] wdata;
    logic [N_REQ-1:0]    byte_ready;
    logic [N_REQ-1:0]    rvalid;
    logic [DW-1:0]       rdata;
    logic [N_REQ-1:0]    gnt;
    logic [N_REQ-1:0]    cs_n;
    // shift engine side
    logic                eng_start;
    logic [DW-1:0]       eng_wdata;
    logic                eng_busy;
    logic                eng_done;
    logic [DW-1:0]       eng_rdata;

    modport master (
        input  req, byte_valid, byte_last, wdata,
        input  eng_busy, eng_done, eng_rdata,
        output byte_ready, rvalid, rdata, gnt, cs_n,
        output eng_start, eng_wdata
    );

    modport slave (
        output req, byte_valid, byte_last, wdata,
        output eng_busy, eng_done, eng_rdata,
        input  byte_ready, rvalid, rdata, gnt, cs_n,
        input  eng_start, eng_wdata
    );
endinterface

// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one SPI shift engine among N_REQ requesters.
// A grant covers a whole multi-byte transaction and sequences CS setup,
// byte issue, CS hold and the inter-transaction gap. All outputs registered.
module spi_bus_arbiter #(
    parameter int N_REQ    = 2,
    parameter int DW       = 8,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int IDLE_GAP = 1
) (
    input  logic              clk,
    input  logic              Rst_n,
    spi_bus_arbiter_if.master bus
);
    localparam int IW      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int MAX_SH  = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int CNT_MAX = (MAX_SH > IDLE_GAP) ? MAX_SH : IDLE_GAP;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ISSUE,
        ST_WAIT,
        ST_HOLD,
        ST_GAP
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [IW-1:0]    last_gnt;
    logic             last_flag;

    logic [N_REQ-1:0] gnt_q;
    logic [N_REQ-1:0] cs_n_q;
    logic [N_REQ-1:0] byte_ready_q;
    logic [N_REQ-1:0] rvalid_q;
    logic [DW-1:0]    rdata_q;
    logic             eng_start_q;
    logic [DW-1:0]    eng_wdata_q;

    logic             found;
    logic [IW-1:0]    nxt_idx;
    logic [N_REQ-1:0] nxt_mask;
    logic [IW-1:0]    cand;
    logic [DW-1:0]    sel_wdata;
    logic             sel_valid;
    logic             sel_last;
    logic             sel_req;

    assign bus.gnt        = gnt_q;
    assign bus.cs_n       = cs_n_q;
    assign bus.byte_ready = byte_ready_q;
    assign bus.rvalid     = rvalid_q;
    assign bus.rdata      = rdata_q;
    assign bus.eng_start  = eng_start_q;
    assign bus.eng_wdata  = eng_wdata_q;

    // Round-robin search: first requester found upward from last_gnt + 1.
    always_comb begin
        found    = 1'b0;
        nxt_idx  = '0;
        nxt_mask = '0;
        cand     = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = IW'((32'(last_gnt) + k) % N_REQ);
            if (!found && bus.req[cand]) begin
                found          = 1'b1;
                nxt_idx        = cand;
                nxt_mask       = '0;
                nxt_mask[cand] = 1'b1;
            end
        end
    end

    // Granted requester's inputs, selected through the one-hot grant register.
    always_comb begin
        sel_wdata = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (gnt_q[i]) begin
                sel_wdata = bus.wdata[i*DW +: DW];
            end
        end
        sel_valid = |(gnt_q & bus.byte_valid);
        sel_last  = |(gnt_q & bus.byte_last);
        sel_req   = |(gnt_q & bus.req);
    end

    // Transaction sequencer; timed phases end when cnt reaches 1 so each
    // phase lasts exactly its programmed number of cycles.
    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            last_gnt     <= IW'(N_REQ - 1);
            last_flag    <= 1'b0;
            gnt_q        <= '0;
            cs_n_q       <= '1;
            byte_ready_q <= '0;
            rvalid_q     <= '0;
            rdata_q      <= '0;
            eng_start_q  <= 1'b0;
            eng_wdata_q  <= '0;
        end else begin
            byte_ready_q <= '0;
            rvalid_q     <= '0;
            eng_start_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        gnt_q    <= nxt_mask;
                        cs_n_q   <= ~nxt_mask;
                        last_gnt <= nxt_idx;
                        cnt      <= CW'(CS_SETUP);
                        state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    cnt <= cnt - CW'(1);
                    if (cnt <= CW'(1)) begin
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (sel_valid && !bus.eng_busy) begin
                        eng_start_q  <= 1'b1;
                        byte_ready_q <= gnt_q;
                        eng_wdata_q  <= sel_wdata;
                        last_flag    <= sel_last;
                        state        <= ST_WAIT;
                    end else if (!sel_req) begin
                        cnt   <= CW'(CS_HOLD);
                        state <= ST_HOLD;
                    end
                end
                ST_WAIT: begin
                    if (bus.eng_done) begin
                        rdata_q  <= bus.eng_rdata;
                        rvalid_q <= gnt_q;
                        if (last_flag) begin
                            cnt   <= CW'(CS_HOLD);
                            state <= ST_HOLD;
                        end else begin
                            state <= ST_ISSUE;
                        end
                    end
                end
                ST_HOLD: begin
                    cnt <= cnt - CW'(1);
                    if (cnt <= CW'(1)) begin
                        cs_n_q <= '1;
                        gnt_q  <= '0;
                        cnt    <= CW'(IDLE_GAP);
                        state  <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    cnt <= cnt - CW'(1);
                    if (cnt <= CW'(1)) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
